// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multicycle MIPS controller.
//   state_t  : 4-bit FSM state encodings (also exported on the debug port)
//   OP_*     : instr[31:26] opcodes recognised by the decoder
//   FN_*     : instr[5:0] R-type funct codes that are supported
//   ALU_*    : 4-bit ALU operation codes, zero-extended to ALUCTRL_W by users
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // Loads and stores share the address-calculation path.
  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mips_mc_aludec.sv
// R-type ALU decoder.
//   funct       in  6          instr[5:0]
//   alucontrol  out ALUCTRL_W  ALU operation, zero-extended 4-bit code
//   funct_valid out 1          funct is one of add/sub/and/or/slt
module mips_mc_aludec
  import mips_mc_pkg::*;
#(
  parameter int ALUCTRL_W = 4
) (
  input  logic [5:0]           funct,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 funct_valid
);

  logic [3:0] code;

  always_comb begin
    code        = ALU_ADD;
    funct_valid = 1'b1;
    case (funct)
      FN_ADD:  code = ALU_ADD;
      FN_SUB:  code = ALU_SUB;
      FN_AND:  code = ALU_AND;
      FN_OR:   code = ALU_OR;
      FN_SLT:  code = ALU_SLT;
      default: funct_valid = 1'b0;
    endcase
  end

  assign alucontrol = ALUCTRL_W'(code);

endmodule

// File: rtl/mips_mc_controller.sv
// Moore control FSM for the multicycle MIPS core with one unified memory.
//   clk, reset(async, active-low)
//   op, funct      : instruction fields from the IR (stable after FETCH)
//   zero           : ALU zero flag, used only for the branch decision
//   mem_ready      : memory completes current access (ignored if MEM_HANDSHAKE=0)
//   iord..pcen     : datapath / memory controls, decoded from state
//   illegal        : single-cycle pulse in DECODE for an unsupported op/funct
//   state          : current state encoding for trace
module mips_mc_controller
  import mips_mc_pkg::*;
#(
  parameter int ALUCTRL_W     = 4,
  parameter bit ENABLE_BNE    = 1'b1,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 iord,
  output logic                 memread,
  output logic                 memwrite,
  output logic                 irwrite,
  output logic                 regdst,
  output logic                 memtoreg,
  output logic                 regwrite,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic [1:0]           pcsrc,
  output logic                 pcen,
  output logic                 illegal,
  output logic [3:0]           state
);

  localparam logic [ALUCTRL_W-1:0] ALUC_ADD = ALUCTRL_W'(ALU_ADD);
  localparam logic [ALUCTRL_W-1:0] ALUC_SUB = ALUCTRL_W'(ALU_SUB);

  state_t                 state_q, state_d;
  logic [ALUCTRL_W-1:0]   fn_alu;
  logic                   fn_valid;
  logic                   rdy;

  mips_mc_aludec #(.ALUCTRL_W(ALUCTRL_W)) u_aludec (
    .funct       (funct),
    .alucontrol  (fn_alu),
    .funct_valid (fn_valid)
  );

  // Without a handshake every memory access completes in one cycle.
  assign rdy = !MEM_HANDSHAKE || mem_ready;

  // Async reset drops the state to RESET immediately, so every enable
  // (decoded from state) falls in the same cycle reset asserts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_RESET;
    else        state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d    = state_q;
    iord       = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    alucontrol = '0;
    pcsrc      = 2'b00;
    pcen       = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        // PC+4 computed every cycle; the IR/PC only latch on the ready cycle.
        memread    = 1'b1;
        alusrcb    = 2'b01;
        alucontrol = ALUC_ADD;
        if (rdy) begin
          irwrite = 1'b1;
          pcen    = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target precomputed into ALUOut regardless of opcode.
        alusrcb    = 2'b11;
        alucontrol = ALUC_ADD;
        case (op)
          OP_RTYPE: begin
            if (fn_valid) state_d = S_EXEC;
            else          illegal = 1'b1;
          end
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_BNE: begin
            if (ENABLE_BNE) state_d = S_BRANCH;
            else            illegal = 1'b1;
          end
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      illegal = 1'b1;
        endcase
        if (illegal) state_d = S_FETCH;
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALUC_ADD;
        if (is_mem_op(op) && op == OP_SW) state_d = S_MEMWR;
        else                              state_d = S_MEMRD;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        memread = 1'b1;
        if (rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        // Held as a single request until accepted, never re-issued.
        iord     = 1'b1;
        memwrite = 1'b1;
        if (rdy) state_d = S_FETCH;
      end
      S_EXEC: begin
        alusrca    = 1'b1;
        alucontrol = fn_alu;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALUC_SUB;
        pcsrc      = 2'b01;
        pcen       = (ENABLE_BNE && op == OP_BNE) ? !zero : zero;
        state_d    = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALUC_ADD;
        state_d    = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcen    = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench: instance 0 uses default parameters, instance 1 has
// ENABLE_BNE=0, MEM_HANDSHAKE=0 and mem_ready tied low.
module tb_mips_mc_controller;
  import mips_mc_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'd0, funct = 6'd0;
  logic       zero = 1'b0, mem_ready = 1'b0;
  logic       mem_ready_tie;

  logic       iord [2], memread [2], memwrite [2], irwrite [2];
  logic       regdst [2], memtoreg [2], regwrite [2], alusrca [2];
  logic [1:0] alusrcb [2], pcsrc [2];
  logic [3:0] alucontrol [2], st [2];
  logic       pcen [2], illegal [2];

  int checks = 0;
  int errors = 0;
  logic [21:0] sb [$];

  assign mem_ready_tie = 1'b0;
  always #5 clk = ~clk;

  mips_mc_controller #(.ALUCTRL_W(4), .ENABLE_BNE(1'b1), .MEM_HANDSHAKE(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .iord(iord[0]), .memread(memread[0]), .memwrite(memwrite[0]), .irwrite(irwrite[0]),
    .regdst(regdst[0]), .memtoreg(memtoreg[0]), .regwrite(regwrite[0]), .alusrca(alusrca[0]),
    .alusrcb(alusrcb[0]), .alucontrol(alucontrol[0]), .pcsrc(pcsrc[0]), .pcen(pcen[0]),
    .illegal(illegal[0]), .state(st[0]));

  mips_mc_controller #(.ALUCTRL_W(4), .ENABLE_BNE(1'b0), .MEM_HANDSHAKE(1'b0)) dut2 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready_tie),
    .iord(iord[1]), .memread(memread[1]), .memwrite(memwrite[1]), .irwrite(irwrite[1]),
    .regdst(regdst[1]), .memtoreg(memtoreg[1]), .regwrite(regwrite[1]), .alusrca(alusrca[1]),
    .alusrcb(alusrcb[1]), .alucontrol(alucontrol[1]), .pcsrc(pcsrc[1]), .pcen(pcen[1]),
    .illegal(illegal[1]), .state(st[1]));

  // {iord,memread,memwrite,irwrite, regdst,memtoreg,regwrite,alusrca,
  //  alusrcb, alucontrol, pcsrc, pcen, illegal}
  localparam logic [17:0] W_ZERO  = 18'b0000_0000_00_0000_00_0_0;
  localparam logic [17:0] W_FETCH = 18'b0101_0000_01_0010_00_1_0;
  localparam logic [17:0] W_FWAIT = 18'b0100_0000_01_0010_00_0_0;
  localparam logic [17:0] W_DEC   = 18'b0000_0000_11_0010_00_0_0;
  localparam logic [17:0] W_DECI  = 18'b0000_0000_11_0010_00_0_1;
  localparam logic [17:0] W_MADR  = 18'b0000_0001_10_0010_00_0_0;
  localparam logic [17:0] W_MRD   = 18'b1100_0000_00_0000_00_0_0;
  localparam logic [17:0] W_MWB   = 18'b0000_0110_00_0000_00_0_0;
  localparam logic [17:0] W_MWR   = 18'b1010_0000_00_0000_00_0_0;
  localparam logic [17:0] W_ALUWB = 18'b0000_1010_00_0000_00_0_0;
  localparam logic [17:0] W_BRT   = 18'b0000_0001_00_0110_01_1_0;
  localparam logic [17:0] W_BRN   = 18'b0000_0001_00_0110_01_0_0;
  localparam logic [17:0] W_AIWB  = 18'b0000_0010_00_0000_00_0_0;
  localparam logic [17:0] W_JMP   = 18'b0000_0000_00_0000_10_1_0;

  function automatic logic [17:0] w_exec(input logic [3:0] alu);
    return {8'b0000_0001, 2'b00, alu, 4'b0000};
  endfunction

  function automatic logic [21:0] obs(input int d);
    return {st[d], iord[d], memread[d], memwrite[d], irwrite[d], regdst[d], memtoreg[d],
            regwrite[d], alusrca[d], alusrcb[d], alucontrol[d], pcsrc[d], pcen[d], illegal[d]};
  endfunction

  task automatic compare(input string tag, input int d);
    logic [21:0] e, o;
    e = sb.pop_front();
    o = obs(d);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // Entered just after a rising edge; drives inputs, checks at the falling edge.
  task automatic step(input string tag, input int d, input logic rdy, input logic z,
                      input logic [3:0] es, input logic [17:0] eo);
    mem_ready = rdy;
    zero      = z;
    sb.push_back({es, eo});
    @(negedge clk);
    compare(tag, d);
    @(posedge clk);
    #1;
  endtask

  task automatic rtype(input logic [5:0] fn, input logic [3:0] alu);
    op = OP_RTYPE; funct = fn;
    step("rt_fetch", 0, 1'b1, 1'b0, S_FETCH, W_FETCH);
    step("rt_decode", 0, 1'b1, 1'b0, S_DECODE, W_DEC);
    step("rt_exec", 0, 1'b1, 1'b0, S_EXEC, w_exec(alu));
    step("rt_aluwb", 0, 1'b1, 1'b0, S_ALUWB, W_ALUWB);
  endtask

  task automatic branch(input string tag, input logic [5:0] opc, input logic z, input logic [17:0] w);
    op = opc;
    step("br_fetch", 0, 1'b1, 1'b0, S_FETCH, W_FETCH);
    step("br_decode", 0, 1'b1, 1'b0, S_DECODE, W_DEC);
    step(tag, 0, 1'b1, z, S_BRANCH, w);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) step("reset_hold", 0, 1'b1, 1'b0, S_RESET, W_ZERO);
    reset = 1'b1;
    step("reset_release", 0, 1'b1, 1'b0, S_RESET, W_ZERO);

    // R-type: each funct reaches EXEC with its ALU code.
    rtype(FN_ADD, 4'b0010);
    rtype(FN_SUB, 4'b0110);
    rtype(FN_AND, 4'b0000);
    rtype(FN_OR,  4'b0001);
    rtype(FN_SLT, 4'b0111);

    // Unsupported funct is flagged and skipped.
    funct = 6'b000111;
    step("badfn_fetch", 0, 1'b1, 1'b0, S_FETCH, W_FETCH);
    step("badfn_decode", 0, 1'b1, 1'b0, S_DECODE, W_DECI);

    // lw with two wait cycles in FETCH and in MEMRD: 9 cycles.
    op = OP_LW;
    step("lw_fwait0", 0, 1'b0, 1'b0, S_FETCH, W_FWAIT);
    step("lw_fwait1", 0, 1'b0, 1'b0, S_FETCH, W_FWAIT);
    step("lw_fetch", 0, 1'b1, 1'b0, S_FETCH, W_FETCH);
    step("lw_decode", 0, 1'b1, 1'b0, S_DECODE, W_DEC);
    step("lw_memadr", 0, 1'b1, 1'b0, S_MEMADR, W_MADR);
    step("lw_rwait0", 0, 1'b0, 1'b0, S_MEMRD, W_MRD);
    step("lw_rwait1", 0, 1'b0, 1'b0, S_MEMRD, W_MRD);
    step("lw_memrd", 0, 1'b1, 1'b0, S_MEMRD, W_MRD);
    step("lw_memwb", 0, 1'b1, 1'b0, S_MEMWB, W_MWB);

    // sw with one wait in MEMWR.
    op = OP_SW;
    step("sw_fetch", 0, 1'b1, 1'b0, S_FETCH, W_FETCH);
    step("sw_decode", 0, 1'b1, 1'b0, S_DECODE, W_DEC);
    step("sw_memadr", 0, 1'b1, 1'b0, S_MEMADR, W_MADR);
    step("sw_wwait", 0, 1'b0, 1'b0, S_MEMWR, W_MWR);
    step("sw_memwr", 0, 1'b1, 1'b0, S_MEMWR, W_MWR);

    branch("beq_z1", OP_BEQ, 1'b1, W_BRT);
    branch("beq_z0", OP_BEQ, 1'b0, W_BRN);
    branch("bne_z1", OP_BNE, 1'b1, W_BRN);
    branch("bne_z0", OP_BNE, 1'b0, W_BRT);

    op = OP_ADDI;
    step("addi_fetch", 0, 1'b1, 1'b0, S_FETCH, W_FETCH);
    step("addi_decode", 0, 1'b1, 1'b0, S_DECODE, W_DEC);
    step("addi_ex", 0, 1'b1, 1'b0, S_ADDIEX, W_MADR);
    step("addi_wb", 0, 1'b1, 1'b0, S_ADDIWB, W_AIWB);

    op = OP_J;
    step("j_fetch", 0, 1'b1, 1'b0, S_FETCH, W_FETCH);
    step("j_decode", 0, 1'b1, 1'b0, S_DECODE, W_DEC);
    step("j_jump", 0, 1'b1, 1'b0, S_JUMP, W_JMP);

    op = 6'b111111;
    step("badop_fetch", 0, 1'b1, 1'b0, S_FETCH, W_FETCH);
    step("badop_decode", 0, 1'b1, 1'b0, S_DECODE, W_DECI);

    // Reset asserted while a store is pending.
    op = OP_SW;
    step("swr_fetch", 0, 1'b1, 1'b0, S_FETCH, W_FETCH);
    step("swr_decode", 0, 1'b1, 1'b0, S_DECODE, W_DEC);
    step("swr_memadr", 0, 1'b1, 1'b0, S_MEMADR, W_MADR);
    step("swr_wwait", 0, 1'b0, 1'b0, S_MEMWR, W_MWR);
    #2 reset = 1'b0;
    sb.push_back({S_RESET, W_ZERO});
    #1 compare("swr_async_reset", 0);
    @(posedge clk);
    #1 reset = 1'b1;
    step("rel2_dut2", 1, 1'b0, 1'b0, S_RESET, W_ZERO);

    // No handshake, mem_ready tied low: sw completes, memwrite for one cycle.
    op = OP_SW;
    step("nh_fetch", 1, 1'b0, 1'b0, S_FETCH, W_FETCH);
    step("nh_decode", 1, 1'b0, 1'b0, S_DECODE, W_DEC);
    step("nh_memadr", 1, 1'b0, 1'b0, S_MEMADR, W_MADR);
    step("nh_memwr", 1, 1'b0, 1'b0, S_MEMWR, W_MWR);
    op = OP_BNE;
    step("nh_fetch2", 1, 1'b0, 1'b0, S_FETCH, W_FETCH);
    step("nobne_decode", 1, 1'b0, 1'b0, S_DECODE, W_DECI);
    step("nobne_fetch", 1, 1'b0, 1'b0, S_FETCH, W_FETCH);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
